// File: rtl/led_1bit.sv
// Single-LED walking light: one-hot WIDTH-bit bus whose lit bit advances every
// STEP_DIV cycles, either rotating around the ends or bouncing between them.
module led_1bit #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_DIV = 1,
  parameter bit          DIR      = 1'b0,
  parameter bit          BOUNCE   = 1'b0
) (
  input  logic             clk,
  input  logic             rs,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned     CW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(STEP_DIV - 1);
  localparam logic [WIDTH-1:0] RESET_Q = DIR ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1);

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam dir_e DIR_INIT = dir_e'(DIR);

  logic [CW-1:0]    cnt;
  logic             step;
  logic             onehot;
  dir_e             dir;
  dir_e             dir_next;
  logic [WIDTH-1:0] q_next;

  assign step   = (cnt == LAST);
  assign onehot = (q != '0) && ((q & (q - WIDTH'(1))) == '0);

  // NOTE: every output of this block gets a default first, so no path leaves
  // q_next or dir_next unassigned and no latch is inferred.
  always_comb begin
    q_next   = q;
    dir_next = dir;
    if (!onehot) begin
      // A corrupted pattern is not walked further; restart from a known state.
      q_next   = RESET_Q;
      dir_next = DIR_INIT;
    end else if (dir == LEFT) begin
      if (BOUNCE && q[WIDTH-1]) begin
        dir_next = RIGHT;
        q_next   = q >> 1;
      end else begin
        q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      end
    end else begin
      if (BOUNCE && q[0]) begin
        dir_next = LEFT;
        q_next   = q << 1;
      end else begin
        q_next = {q[0], q[WIDTH-1:1]};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from values sampled at the same clock edge.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      cnt <= '0;
      dir <= DIR_INIT;
      q   <= RESET_Q;
    end else begin
      cnt <= step ? '0 : cnt + CW'(1);
      if (step) begin
        q   <= q_next;
        dir <= dir_next;
      end
    end
  end

endmodule

// File: tb/tb_led_1bit.sv
// Scoreboard bench for led_1bit: five parameterisations share one clock and
// reset; expected patterns come from a closed-form position model.
module tb_led_1bit;

  localparam int NI = 5;
  localparam int W  [NI] = '{8, 8, 8, 8, 5};
  localparam int SD [NI] = '{1, 4, 1, 1, 3};
  localparam bit DR [NI] = '{0, 0, 1, 0, 1};
  localparam bit BN [NI] = '{0, 0, 0, 1, 1};

  logic       clk;
  logic       rs;
  logic [7:0] q0, q1, q2, q3;
  logic [4:0] q4;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;   // rising edges seen with rs high since the last reset

  typedef logic [NI-1:0][31:0] exp_t;
  exp_t sb[$];

  led_1bit #(.WIDTH(8), .STEP_DIV(1), .DIR(1'b0), .BOUNCE(1'b0)) u0 (.clk(clk), .rs(rs), .q(q0));
  led_1bit #(.WIDTH(8), .STEP_DIV(4), .DIR(1'b0), .BOUNCE(1'b0)) u1 (.clk(clk), .rs(rs), .q(q1));
  led_1bit #(.WIDTH(8), .STEP_DIV(1), .DIR(1'b1), .BOUNCE(1'b0)) u2 (.clk(clk), .rs(rs), .q(q2));
  led_1bit #(.WIDTH(8), .STEP_DIV(1), .DIR(1'b0), .BOUNCE(1'b1)) u3 (.clk(clk), .rs(rs), .q(q3));
  led_1bit #(.WIDTH(5), .STEP_DIV(3), .DIR(1'b1), .BOUNCE(1'b1)) u4 (.clk(clk), .rs(rs), .q(q4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit position after `edges` running edges: whole steps taken, then either a
  // modulo walk or a triangle wave over 2*(w-1) steps, mirrored for DIR=1.
  function automatic logic [31:0] model_q(int w, int sd, bit dir, bit bounce, int edges);
    int s, pos, p, d;
    s = edges / sd;
    if (!bounce) begin
      pos = dir ? (w - 1 - (s % w)) : (s % w);
    end else begin
      p   = s % (2 * (w - 1));
      d   = (p <= w - 1) ? p : 2 * (w - 1) - p;
      pos = dir ? (w - 1 - d) : d;
    end
    return 32'(1) << pos;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push_expected(input int edges);
    exp_t e;
    for (int i = 0; i < NI; i++) e[i] = model_q(W[i], SD[i], DR[i], BN[i], edges);
    sb.push_back(e);
  endtask

  // One clock cycle: account for the edge, predict the pattern seen at the
  // following falling edge, then set rs for the rest of the cycle.
  task automatic run_cycle(input logic rs_mid);
    @(posedge clk);
    #1;
    if (rs) n++;
    else    n = 0;
    push_expected(rs_mid ? n : 0);
    #2 rs = rs_mid;
  endtask

  function automatic bit is_onehot(logic [31:0] v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Monitor: every falling edge the DUTs present a pattern; compare it with
  // the oldest prediction and confirm it is one-hot.
  initial begin
    exp_t e;
    logic [NI-1:0][31:0] act;
    forever begin
      @(negedge clk);
      act[0] = 32'(q0);
      act[1] = 32'(q1);
      act[2] = 32'(q2);
      act[3] = 32'(q3);
      act[4] = 32'(q4);
      for (int i = 0; i < NI; i++)
        check($sformatf("inst%0d onehot", i), 32'(is_onehot(act[i])), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < NI; i++)
          check($sformatf("inst%0d q", i), act[i], e[i]);
      end
    end
  end

  initial begin
    rs = 1'b0;
    repeat (3) run_cycle(1'b0);
    // Long enough for full rotations, STEP_DIV=4 holds and a full bounce period.
    repeat (40) run_cycle(1'b1);
    // Run the default instance to 8'h10, then pulse reset between edges.
    repeat (4) run_cycle(1'b1);
    run_cycle(1'b0);
    repeat (20) run_cycle(1'b1);
    repeat (1000) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 3)) run_cycle(1'b0);
      end else begin
        run_cycle(1'b1);
      end
    end
    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
